// File: rtl/rvm_axi4_router.sv
// rvm_axi4_router: routes one AXI4 master to NSLV slaves by address decode, with one outstanding
// write and one outstanding read; unmapped addresses are absorbed and answered with DECERR.
module rvm_axi4_router #(
  parameter int NSLV = 2,
  parameter logic [NSLV*32-1:0] SLV_BASE = {32'h0000_0000, 32'h8000_0000},
  parameter logic [NSLV*32-1:0] SLV_MASK = {32'hF000_0000, 32'h8000_0000}
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [31:0]       S_AWADDR,
  input  logic [7:0]        S_AWLEN,
  input  logic [2:0]        S_AWSIZE,
  input  logic [1:0]        S_AWBURST,
  input  logic              S_AWVALID,
  output logic              S_AWREADY,
  input  logic [31:0]       S_WDATA,
  input  logic [3:0]        S_WSTRB,
  input  logic              S_WLAST,
  input  logic              S_WVALID,
  output logic              S_WREADY,
  output logic [1:0]        S_BRESP,
  output logic              S_BVALID,
  input  logic              S_BREADY,
  input  logic [31:0]       S_ARADDR,
  input  logic [7:0]        S_ARLEN,
  input  logic [2:0]        S_ARSIZE,
  input  logic [1:0]        S_ARBURST,
  input  logic              S_ARVALID,
  output logic              S_ARREADY,
  output logic [31:0]       S_RDATA,
  output logic [1:0]        S_RRESP,
  output logic              S_RLAST,
  output logic              S_RVALID,
  input  logic              S_RREADY,
  output logic [NSLV*32-1:0] M_AWADDR,
  output logic [NSLV*8-1:0]  M_AWLEN,
  output logic [NSLV*3-1:0]  M_AWSIZE,
  output logic [NSLV*2-1:0]  M_AWBURST,
  output logic [NSLV-1:0]    M_AWVALID,
  input  logic [NSLV-1:0]    M_AWREADY,
  output logic [NSLV*32-1:0] M_WDATA,
  output logic [NSLV*4-1:0]  M_WSTRB,
  output logic [NSLV-1:0]    M_WLAST,
  output logic [NSLV-1:0]    M_WVALID,
  input  logic [NSLV-1:0]    M_WREADY,
  input  logic [NSLV*2-1:0]  M_BRESP,
  input  logic [NSLV-1:0]    M_BVALID,
  output logic [NSLV-1:0]    M_BREADY,
  output logic [NSLV*32-1:0] M_ARADDR,
  output logic [NSLV*8-1:0]  M_ARLEN,
  output logic [NSLV*3-1:0]  M_ARSIZE,
  output logic [NSLV*2-1:0]  M_ARBURST,
  output logic [NSLV-1:0]    M_ARVALID,
  input  logic [NSLV-1:0]    M_ARREADY,
  input  logic [NSLV*32-1:0] M_RDATA,
  input  logic [NSLV*2-1:0]  M_RRESP,
  input  logic [NSLV-1:0]    M_RLAST,
  input  logic [NSLV-1:0]    M_RVALID,
  output logic [NSLV-1:0]    M_RREADY
);
  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_EDATA, W_ERESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} rstate_t;
  wstate_t ws, ws_n;
  rstate_t rs, rs_n;
  logic [31:0] aw_addr, ar_addr, r_data;
  logic [7:0] aw_len, ar_len, cnt;
  logic [2:0] aw_size, ar_size, aw_dec, ar_dec;
  logic [1:0] aw_burst, ar_burst, aw_sel, ar_sel, b_resp, r_resp;
  logic aw_rdy, w_rdy, b_vld, ar_rdy, r_vld, r_last;
  // {miss, index}: scanning from the top down leaves the lowest matching index
  function automatic logic [2:0] decode(input logic [31:0] addr);
    logic [2:0] r;
    r = 3'b100;
    for (int i = NSLV - 1; i >= 0; i--)
      if ((addr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) r = {1'b0, 2'(i)};
    return r;
  endfunction
  assign aw_dec = decode(S_AWADDR);
  assign ar_dec = decode(S_ARADDR);
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      ws <= W_IDLE;
      aw_addr <= '0;
      aw_len <= '0;
      aw_size <= '0;
      aw_burst <= '0;
      aw_sel <= '0;
    end else begin
      ws <= ws_n;
      if (ws == W_IDLE && S_AWVALID) begin
        aw_addr <= S_AWADDR;
        aw_len <= S_AWLEN;
        aw_size <= S_AWSIZE;
        aw_burst <= S_AWBURST;
        aw_sel <= aw_dec[1:0];
      end
    end
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      rs <= R_IDLE;
      ar_addr <= '0;
      ar_len <= '0;
      ar_size <= '0;
      ar_burst <= '0;
      ar_sel <= '0;
      cnt <= '0;
    end else begin
      rs <= rs_n;
      if (rs == R_IDLE && S_ARVALID) begin
        ar_addr <= S_ARADDR;
        ar_len <= S_ARLEN;
        ar_size <= S_ARSIZE;
        ar_burst <= S_ARBURST;
        ar_sel <= ar_dec[1:0];
      end
      if (rs == R_ERR && S_RREADY) cnt <= cnt == ar_len ? 8'd0 : cnt + 8'd1;
    end
  always_comb begin
    aw_rdy = 1'b0;
    w_rdy = 1'b0;
    b_vld = 1'b0;
    b_resp = 2'b00;
    ar_rdy = 1'b0;
    r_vld = 1'b0;
    r_last = 1'b0;
    r_resp = 2'b00;
    r_data = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (aw_sel == 2'(i)) begin
        aw_rdy = M_AWREADY[i];
        w_rdy = M_WREADY[i];
        b_vld = M_BVALID[i];
        b_resp = M_BRESP[i*2 +: 2];
      end
      if (ar_sel == 2'(i)) begin
        ar_rdy = M_ARREADY[i];
        r_vld = M_RVALID[i];
        r_last = M_RLAST[i];
        r_resp = M_RRESP[i*2 +: 2];
        r_data = M_RDATA[i*32 +: 32];
      end
    end
  end
  always_comb begin
    ws_n = ws;
    unique case (ws)
      W_IDLE:  if (S_AWVALID) ws_n = aw_dec[2] ? W_EDATA : W_ADDR;
      W_ADDR:  if (aw_rdy) ws_n = W_DATA;
      W_DATA:  if (S_WVALID && w_rdy && S_WLAST) ws_n = W_RESP;
      W_RESP:  if (b_vld && S_BREADY) ws_n = W_IDLE;
      W_EDATA: if (S_WVALID && S_WLAST) ws_n = W_ERESP;
      W_ERESP: if (S_BREADY) ws_n = W_IDLE;
      default: ws_n = W_IDLE;
    endcase
  end
  always_comb begin
    rs_n = rs;
    unique case (rs)
      R_IDLE: if (S_ARVALID) rs_n = ar_dec[2] ? R_ERR : R_ADDR;
      R_ADDR: if (ar_rdy) rs_n = R_DATA;
      R_DATA: if (r_vld && S_RREADY && r_last) rs_n = R_IDLE;
      R_ERR:  if (S_RREADY && cnt == ar_len) rs_n = R_IDLE;
      default: rs_n = R_IDLE;
    endcase
  end
  assign S_AWREADY = ws == W_IDLE;
  assign S_WREADY = ws == W_DATA ? w_rdy : ws == W_EDATA;
  assign S_BVALID = ws == W_RESP ? b_vld : ws == W_ERESP;
  assign S_BRESP = ws == W_RESP ? b_resp : ws == W_ERESP ? 2'b11 : 2'b00;
  assign S_ARREADY = rs == R_IDLE;
  assign S_RVALID = rs == R_DATA ? r_vld : rs == R_ERR;
  assign S_RDATA = rs == R_DATA ? r_data : '0;
  assign S_RRESP = rs == R_DATA ? r_resp : rs == R_ERR ? 2'b11 : 2'b00;
  assign S_RLAST = rs == R_DATA ? r_last : rs == R_ERR && cnt == ar_len;
  for (genvar g = 0; g < NSLV; g++) begin : g_slv
    localparam logic [1:0] IDX = 2'(g);
    assign M_AWADDR[g*32 +: 32] = aw_addr;
    assign M_AWLEN[g*8 +: 8] = aw_len;
    assign M_AWSIZE[g*3 +: 3] = aw_size;
    assign M_AWBURST[g*2 +: 2] = aw_burst;
    assign M_AWVALID[g] = ws == W_ADDR && aw_sel == IDX;
    assign M_WDATA[g*32 +: 32] = S_WDATA;
    assign M_WSTRB[g*4 +: 4] = S_WSTRB;
    assign M_WLAST[g] = S_WLAST;
    assign M_WVALID[g] = ws == W_DATA && aw_sel == IDX && S_WVALID;
    assign M_BREADY[g] = ws == W_RESP && aw_sel == IDX && S_BREADY;
    assign M_ARADDR[g*32 +: 32] = ar_addr;
    assign M_ARLEN[g*8 +: 8] = ar_len;
    assign M_ARSIZE[g*3 +: 3] = ar_size;
    assign M_ARBURST[g*2 +: 2] = ar_burst;
    assign M_ARVALID[g] = rs == R_ADDR && ar_sel == IDX;
    assign M_RREADY[g] = rs == R_DATA && ar_sel == IDX && S_RREADY;
  end
endmodule
